// File: rtl/udp_sweep_sequencer.sv
// Sweeps every enabled input vector of the 4-in/2-out UDP circuit, holds each one for
// HOLD_CYCLES cycles, samples E/F in the last hold cycle and scores them against a latched truth table.
module udp_sweep_sequencer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] vector_mask,
  input  logic [15:0] expected_e,
  input  logic [15:0] expected_f,
  input  logic        e_in,
  input  logic        f_in,
  output logic        a_out,
  output logic        b_out,
  output logic        c_out,
  output logic        d_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic        fail_valid,
  output logic [3:0]  first_fail,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] mask_q, mask_d;
  logic [15:0] exp_e_q, exp_e_d;
  logic [15:0] exp_f_q, exp_f_d;
  logic [4:0]  err_count_q, err_count_d;
  logic        fail_valid_q, fail_valid_d;
  logic [3:0]  first_fail_q, first_fail_d;
  logic        pass_q, pass_d;
  logic [3:0]  abcd_q, abcd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  nxt;

  // Returns {found, index} of the lowest set mask bit at or above lo.
  function automatic logic [4:0] find_next(input logic [15:0] m, input logic [4:0] lo);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i] && (5'(i) >= lo)) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  // start is a level sampled only in IDLE; no handshake back other than busy/done.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    exp_e_d      = exp_e_q;
    exp_f_d      = exp_f_q;
    err_count_d  = err_count_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    nxt          = 5'd0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d       = vector_mask;
          exp_e_d      = expected_e;
          exp_f_d      = expected_f;
          err_count_d  = 5'd0;
          fail_valid_d = 1'b0;
          first_fail_d = 4'd0;
          pass_d       = 1'b0;
          cnt_d        = 8'd0;
          nxt          = find_next(vector_mask, 5'd0);
          if (nxt[4]) begin
            state_d = APPLY;
            idx_d   = nxt[3:0];
          end else begin
            state_d = DONE;
            pass_d  = 1'b1;
          end
        end
      end
      APPLY: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = 8'd0;
          if ((e_in != exp_e_q[idx_q]) || (f_in != exp_f_q[idx_q])) begin
            err_count_d = err_count_q + 5'd1;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              first_fail_d = idx_q;
            end
          end
          nxt = find_next(mask_q, {1'b0, idx_q} + 5'd1);
          if (nxt[4]) begin
            idx_d = nxt[3:0];
          end else begin
            state_d = DONE;
            pass_d  = (err_count_d == 5'd0);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == APPLY);
    done_d = (state_d == DONE);
    abcd_d = busy_d ? idx_d : 4'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      cnt_q        <= 8'd0;
      mask_q       <= 16'd0;
      exp_e_q      <= 16'd0;
      exp_f_q      <= 16'd0;
      err_count_q  <= 5'd0;
      fail_valid_q <= 1'b0;
      first_fail_q <= 4'd0;
      pass_q       <= 1'b0;
      abcd_q       <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      exp_e_q      <= exp_e_d;
      exp_f_q      <= exp_f_d;
      err_count_q  <= err_count_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
      abcd_q       <= abcd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign {a_out, b_out, c_out, d_out} = abcd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_valid = fail_valid_q;
  assign first_fail = first_fail_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_udp_sweep_sequencer.sv
// Bench for udp_sweep_sequencer: a behavioural UDP circuit feeds E/F back, and a queue
// holds the expected ABCD sequence of each sweep.
module tb_udp_sweep_sequencer;
  localparam int H = 4;

  logic        clock = 1'b0;
  logic        reset, start, start1;
  logic [15:0] vector_mask, expected_e, expected_f;
  logic        a_out, b_out, c_out, d_out, e_in, f_in;
  logic        busy, done, pass, fail_valid;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;
  logic [1:0]  state_dbg;
  logic        a1, b1, c1, d1, e1, f1;
  logic        busy1, done1, pass1, fail_valid1;
  logic [4:0]  err_count1;
  logic [3:0]  first_fail1;
  logic [1:0]  state_dbg1;

  int          total = 0;
  int          bad = 0;
  logic [3:0]  exp_q[$];
  logic [15:0] ref_e, ref_f;

  always #5 clock = ~clock;

  // Behavioural model of the circuit under sweep.
  function automatic logic udp_e(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & ~v[0]);
  endfunction
  function automatic logic udp_f(input logic [3:0] v);
    return (v[3] ^ v[1]) | (v[2] & v[0]);
  endfunction

  assign e_in = udp_e({a_out, b_out, c_out, d_out});
  assign f_in = udp_f({a_out, b_out, c_out, d_out});
  assign e1   = udp_e({a1, b1, c1, d1});
  assign f1   = udp_f({a1, b1, c1, d1});

  udp_sweep_sequencer #(.HOLD_CYCLES(H)) dut (
    .clock(clock), .reset(reset), .start(start), .vector_mask(vector_mask),
    .expected_e(expected_e), .expected_f(expected_f), .e_in(e_in), .f_in(f_in),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail(first_fail), .state_dbg(state_dbg)
  );

  udp_sweep_sequencer #(.HOLD_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .vector_mask(vector_mask),
    .expected_e(expected_e), .expected_f(expected_f), .e_in(e1), .f_in(f1),
    .a_out(a1), .b_out(b1), .c_out(c1), .d_out(d1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .fail_valid(fail_valid1), .first_fail(first_fail1), .state_dbg(state_dbg1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every busy cycle must drive the next queued vector.
  always @(negedge clock) begin
    if (!reset && busy) begin
      if (exp_q.size() == 0) check("unexpected_busy", 32'd1, 32'd0);
      else check("abcd", {28'd0, a_out, b_out, c_out, d_out}, {28'd0, exp_q.pop_front()});
    end
  end

  task automatic sweep(input logic [15:0] m, input logic [15:0] ee, input logic [15:0] ef,
                       input bit disturb, input bit start_in_done);
    int n, cyc, exp_err;
    logic [3:0] exp_first;
    bit fv;
    n = 0; exp_err = 0; fv = 0; exp_first = 4'd0;
    for (int v = 0; v < 16; v++) begin
      if (m[v]) begin
        n++;
        for (int k = 0; k < H; k++) exp_q.push_back(4'(v));
        if (ee[v] != ref_e[v] || ef[v] != ref_f[v]) begin
          if (!fv) exp_first = 4'(v);
          fv = 1;
          exp_err++;
        end
      end
    end
    @(negedge clock);
    vector_mask = m; expected_e = ee; expected_f = ef; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 2000) begin
      if (disturb && cyc == 3) begin
        start       = 1'b1;
        vector_mask = 16'($urandom_range(0, 65535));
        expected_e  = 16'($urandom_range(0, 65535));
        expected_f  = 16'($urandom_range(0, 65535));
      end
      if (disturb && cyc == 4) start = 1'b0;
      @(negedge clock);
      cyc++;
    end
    check("done_cycle", cyc, n * H + 1);
    check("pass", {31'd0, pass}, {31'd0, exp_err == 0});
    check("err_count", {27'd0, err_count}, exp_err);
    check("fail_valid", {31'd0, fail_valid}, {31'd0, fv});
    if (fv) check("first_fail", {28'd0, first_fail}, {28'd0, exp_first});
    check("abcd_in_done", {28'd0, a_out, b_out, c_out, d_out}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    if (start_in_done) start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("idle_after_done", {28'd0, busy, done, state_dbg}, 32'd0);
    check("err_count_held", {27'd0, err_count}, exp_err);
    check("pass_held", {31'd0, pass}, {31'd0, exp_err == 0});
  endtask

  initial begin
    for (int v = 0; v < 16; v++) begin
      ref_e[v] = udp_e(4'(v));
      ref_f[v] = udp_f(4'(v));
    end
    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    vector_mask = 16'd0; expected_e = 16'd0; expected_f = 16'd0;
    repeat (3) @(negedge clock);
    check("rst_abcd", {28'd0, a_out, b_out, c_out, d_out}, 32'd0);
    check("rst_flags", {28'd0, busy, done, pass, fail_valid}, 32'd0);
    check("rst_err", {27'd0, err_count}, 32'd0);
    check("rst_first", {28'd0, first_fail}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b0;

    sweep(16'hFFFF, ref_e, ref_f, 1'b0, 1'b0);
    sweep(16'hFFFF, ref_e ^ 16'h0020, ref_f ^ 16'h1020, 1'b0, 1'b0);
    sweep(16'hFEFF, ref_e, ref_f, 1'b0, 1'b0);
    sweep(16'h0000, ref_e, ref_f, 1'b0, 1'b0);

    // Reset while vector 7 is on ABCD, with start held high alongside reset.
    @(negedge clock);
    vector_mask = 16'hFFFF; expected_e = ref_e ^ 16'h0004; expected_f = ref_f; start = 1'b1;
    for (int v = 0; v < 16; v++) for (int k = 0; k < H; k++) exp_q.push_back(4'(v));
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 200 && {a_out, b_out, c_out, d_out} != 4'd7; i++) @(negedge clock);
    check("reach_vec7", {28'd0, a_out, b_out, c_out, d_out}, 32'd7);
    check("err_before_reset", {27'd0, err_count}, 32'd1);
    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    check("mid_rst_abcd", {28'd0, a_out, b_out, c_out, d_out}, 32'd0);
    check("mid_rst_flags", {28'd0, busy, done, pass, fail_valid}, 32'd0);
    check("mid_rst_err", {27'd0, err_count}, 32'd0);
    check("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b0; start = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("no_start_after_rst", {31'd0, busy}, 32'd0);

    sweep(16'hFFFF, ref_e, ref_f, 1'b0, 1'b0);
    sweep(16'hFFFF, ref_e ^ 16'h8001, ref_f ^ 16'h0100, 1'b1, 1'b1);

    // HOLD_CYCLES=1 instance: one vector per cycle.
    @(negedge clock);
    vector_mask = 16'hFFFF; expected_e = ref_e; expected_f = ref_f; start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("h1_abcd", {28'd0, a1, b1, c1, d1}, k);
      check("h1_busy", {31'd0, busy1}, 32'd1);
      @(negedge clock);
    end
    check("h1_done", {31'd0, done1}, 32'd1);
    check("h1_pass", {30'd0, pass1, fail_valid1}, 32'd2);
    check("h1_err", {27'd0, err_count1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
